// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I datapath types
// Word type and the fetch-to-execute bundle carried through the queue.
package rv32i_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        word_t npc;
    } fe_bundle_t;

    function automatic logic pc_misaligned(input word_t pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_execute_queue.sv
// rtl/fetch_execute_queue.sv - in-order fetch-to-execute bundle queue
// Registered-occupancy FIFO; in_ready never depends on out_ready, no bypass.
module fetch_execute_queue
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  word_t                    in_pc,
    input  word_t                    in_instr,
    input  word_t                    in_npc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output word_t                    out_pc,
    output word_t                    out_instr,
    output word_t                    out_npc,
    output logic                     out_misaligned,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fe_bundle_t       mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;
    fe_bundle_t       head;
    fe_bundle_t       in_bundle;

    assign in_bundle = '{pc: in_pc, instr: in_instr, npc: in_npc};

    // Ready is derived from registered occupancy only, so execute stalls never reach fetch combinationally.
    assign in_ready  = !RST && !flush && (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rptr    <= '0;
            wptr    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rptr    <= '0;
            wptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= in_bundle;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head           = mem[rptr];
    assign out_pc         = head.pc;
    assign out_instr      = head.instr;
    assign out_npc        = head.npc;
    assign out_misaligned = out_valid && pc_misaligned(head.pc);
    assign count          = count_q;

endmodule

// File: doc/fetch_execute_queue.md
# fetch_execute_queue

Execute-side receiver for the fetch-to-execute instruction stream. Accepts fetched instruction bundles (pc, instr, npc) from the fetch stage through a valid/ready handshake, buffers them in a small in-order queue, and presents the oldest bundle to the execute stage. A flush from execute (branch/jump/exception redirect) discards every buffered bundle in one cycle. The block decouples fetch from execute stalls without combinational ready paths from execute back to fetch.

## Interface
Parameters:
- DEPTH, 2, number of queue entries; power of two, ≥2.

Ports (one clock `CLK`; reset `RST` is synchronous and active-high):
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous active-high reset
- in_valid  input  1  fetch presents a bundle
- in_ready  output  1  queue accepts the bundle this cycle
- in_pc  input  32  word_t, fetch pc
- in_instr  input  32  word_t, fetched instruction
- in_npc  input  32  word_t, fetch-predicted next pc
- out_valid  output  1  head bundle is valid
- out_ready  input  1  execute consumes head this cycle
- out_pc  output  32  word_t, head pc
- out_instr  output  32  word_t, head instruction
- out_npc  output  32  word_t, head next pc
- out_misaligned  output  1  head pc[1:0] != 0
- flush  input  1  discard all queued and incoming bundles
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of {pc, instr, npc}; read pointer, write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter 0..DEPTH.
- Push: in_valid && in_ready → write entry at wptr, wptr+1.
- Pop: out_valid && out_ready → rptr+1.
- in_ready = (count != DEPTH) && !flush. Depends only on registered state and flush; never on out_ready.
- out_valid = (count != 0). out_pc/out_instr/out_npc driven from entry at rptr; values when out_valid=0 are don't-care but must not be X after reset (storage reset to 0).
- out_misaligned = out_valid && (out_pc[1:0] != 2'b00).
- count next = count + push − pop; simultaneous push and pop leaves count unchanged.
- Full (count==DEPTH): in_ready=0; pop still allowed; push resumes the following cycle.
- Empty (count==0): out_valid=0; push-and-pop of the same bundle in one cycle is NOT supported (no bypass); a bundle is visible one cycle after acceptance.
- Flush: highest priority. Next cycle count=0, rptr=wptr=0, out_valid=0. Bundle on in_valid during flush is dropped (in_ready=0). Pop during flush is irrelevant; no state beyond reset values survives.
- Reset: same effect as flush plus storage cleared to 0; all outputs 0 during and after reset except in_ready, which is 1 in the cycle after RST deasserts (in_ready=1 while RST high is permitted to be 0; required: in_ready=0 while RST=1).

## Timing
- Accept-to-visible latency: 1 cycle (bundle accepted at edge N appears on out_* after edge N).
- Throughput: 1 bundle/cycle sustained when out_ready=1 continuously and DEPTH≥2.
- Flush asserted in cycle N → out_valid=0 and count=0 from cycle N+1; in_ready=0 in cycle N, 1 in N+1 (unless flush held).
- Reset values after first edge with RST=1: count=0, out_valid=0, out_pc/out_instr/out_npc=0, out_misaligned=0, in_ready=0 while RST held.
- No combinational path out_ready→in_ready or in_valid→out_valid.

## Structure
- word_t from rv32i_types_pkg for all 32-bit fields.
- Add fe_bundle_t (packed struct {pc, instr, npc}) to rv32i_types_pkg; queue storage is an array of fe_bundle_t.
- Single module; no sub-module.

## Test plan
- Reset: hold RST 2 cycles → count=0, out_valid=0, out_*=0, in_ready=0; release → in_ready=1.
- Single pass: push {pc=0x200, instr=0x00000013, npc=0x204} with out_ready=0 → next cycle out_valid=1, out_pc=0x200, count=1; assert out_ready → count=0.
- Fill/backpressure (DEPTH=2): push pc 0x200, 0x204, 0x208 back-to-back, out_ready=0 → first two accepted, in_ready=0 on third, count=2; release out_ready → order 0x200, 0x204, then 0x208 accepted and emitted.
- Streaming wrap: 20 consecutive bundles pc 0x0..0x4C with out_ready=1 → all emitted in order, count stays 1 steady-state, pointers wrap correctly.
- Flush: count=2, assert flush with in_valid=1 pc=0x300 → next cycle count=0, out_valid=0, 0x300 never emitted; subsequent push pc=0x400 emitted normally.
- Misaligned: push pc=0x202 → out_misaligned=1 with out_valid; pc=0x204 → 0.
